// File: rtl/easy_fifo_pkt.sv
// easy_fifo_pkt: single-clock FIFO with packet commit/drop.
// Words are written speculatively behind wr_ptr and become visible to the
// reader only once commit_ptr passes them. Packets that cannot fit are
// dropped automatically and the rest of the packet is swallowed.
module easy_fifo_pkt #(
  parameter int DWIDTH        = 32,
  parameter int DEPTH         = 64,
  parameter int PKT_MODE      = 1,
  parameter int OUTPUT_REG    = 1,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DWIDTH-1:0]        wr_data,
  input  logic                     wr_en,
  input  logic                     wr_last,
  input  logic                     wr_drop,
  output logic                     wr_full,
  output logic                     wr_afull,
  output logic                     pkt_overflow,
  input  logic                     rd_en,
  output logic [DWIDTH-1:0]        rd_data,
  output logic                     rd_last,
  output logic                     rd_empty,
  output logic                     rd_aempty,
  output logic [$clog2(DEPTH):0]   fifo_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int MW = DWIDTH + 1;
  localparam logic [PW-1:0] ONE_P    = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_P  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_P = PW'(AEMPTY_THRESH);
  localparam logic          PKT_P    = (PKT_MODE != 0);

  typedef enum logic [0:0] {ST_NORMAL = 1'b0, ST_DISCARD = 1'b1} state_t;

  logic [MW-1:0] mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r, commit_ptr_r, rd_ptr_r;
  logic [PW-1:0] wr_ptr_nxt_s, commit_ptr_nxt_s;
  logic [PW-1:0] spec_occ_s, commit_occ_s;
  state_t        state_r, state_nxt_s;
  logic          pkt_overflow_r;
  logic          wr_full_s, wr_accept_s, drop_s, store_s, commit_s, auto_drop_s;
  logic          has_word_s, rd_pop_s, rd_empty_s;
  logic [MW-1:0] rd_word_s;

  assign spec_occ_s   = wr_ptr_r - rd_ptr_r;
  assign commit_occ_s = commit_ptr_r - rd_ptr_r;
  assign has_word_s   = (rd_ptr_r != commit_ptr_r);
  assign wr_accept_s  = wr_en & ~wr_full_s;
  assign drop_s       = PKT_P & wr_drop;
  // In DISCARD nothing is stored; only NORMAL writes that are not dropped land in memory.
  assign store_s      = (state_r == ST_NORMAL) & wr_accept_s & ~drop_s;
  assign commit_s     = store_s & (wr_last | ~PKT_P);
  // A non-last word that fills memory while nothing is committed can never be completed.
  assign auto_drop_s  = PKT_P & store_s & ~wr_last &
                        ((wr_ptr_r + ONE_P - rd_ptr_r) == DEPTH_P) &
                        (commit_ptr_r == rd_ptr_r);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_NORMAL;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: enter DISCARD on auto-drop, leave it on a last word or an explicit drop.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_NORMAL: begin
        if (auto_drop_s) state_nxt_s = ST_DISCARD;
        else             state_nxt_s = ST_NORMAL;
      end
      ST_DISCARD: begin
        if (drop_s || (wr_en && wr_last)) state_nxt_s = ST_NORMAL;
        else                              state_nxt_s = ST_DISCARD;
      end
      default: state_nxt_s = ST_NORMAL;
    endcase
  end

  // FSM outputs: back-pressure only applies in NORMAL; DISCARD swallows everything.
  always_comb begin
    wr_full_s = 1'b0;
    case (state_r)
      ST_NORMAL:  wr_full_s = (spec_occ_s == DEPTH_P);
      ST_DISCARD: wr_full_s = 1'b0;
      default:    wr_full_s = 1'b0;
    endcase
  end

  // Write/commit pointer next values: drop and auto-drop rewind to the last commit point.
  always_comb begin
    wr_ptr_nxt_s     = wr_ptr_r;
    commit_ptr_nxt_s = commit_ptr_r;
    if (drop_s || auto_drop_s) begin
      wr_ptr_nxt_s = commit_ptr_r;
    end else if (store_s) begin
      wr_ptr_nxt_s = wr_ptr_r + ONE_P;
      if (commit_s) commit_ptr_nxt_s = wr_ptr_r + ONE_P;
      else          commit_ptr_nxt_s = commit_ptr_r;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
  end

  // Pointer registers and the one-cycle overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r       <= {PW{1'b0}};
      commit_ptr_r   <= {PW{1'b0}};
      rd_ptr_r       <= {PW{1'b0}};
      pkt_overflow_r <= 1'b0;
    end else begin
      wr_ptr_r       <= wr_ptr_nxt_s;
      commit_ptr_r   <= commit_ptr_nxt_s;
      pkt_overflow_r <= auto_drop_s;
      if (rd_pop_s) rd_ptr_r <= rd_ptr_r + ONE_P;
    end
  end

  // Storage array; contents are meaningless until committed, so no reset.
  always_ff @(posedge clk) begin
    if (store_s) mem_r[wr_ptr_r[AW-1:0]] <= {wr_last, wr_data};
  end

  generate
    if (OUTPUT_REG != 0) begin : g_oreg
      logic          out_valid_r;
      logic [MW-1:0] out_word_r;
      logic          load_s;

      assign load_s     = has_word_s & (~out_valid_r | rd_en);
      assign rd_pop_s   = load_s;
      assign rd_empty_s = ~out_valid_r;
      assign rd_word_s  = out_word_r;

      // Output stage: refill whenever empty or being consumed and a committed word exists.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_r <= 1'b0;
          out_word_r  <= {MW{1'b0}};
        end else if (load_s) begin
          out_valid_r <= 1'b1;
          out_word_r  <= mem_r[rd_ptr_r[AW-1:0]];
        end else if (rd_en) begin
          out_valid_r <= 1'b0;
        end
      end
    end else begin : g_comb
      assign rd_pop_s   = rd_en & has_word_s;
      assign rd_empty_s = ~has_word_s;
      // Show zero while empty so uncommitted or stale memory never reaches the port.
      assign rd_word_s  = has_word_s ? mem_r[rd_ptr_r[AW-1:0]] : {MW{1'b0}};
    end
  endgenerate

  assign wr_full      = wr_full_s;
  assign wr_afull     = (spec_occ_s >= AFULL_P);
  assign pkt_overflow = pkt_overflow_r;
  assign rd_data      = rd_word_s[DWIDTH-1:0];
  assign rd_last      = rd_word_s[DWIDTH];
  assign rd_empty     = rd_empty_s;
  assign rd_aempty    = (commit_occ_s <= AEMPTY_P);
  assign fifo_cnt     = commit_occ_s;

endmodule

// File: tb/tb_easy_fifo_pkt.sv
// Bench for easy_fifo_pkt: a packet-mode instance with registered output and a
// plain-FIFO instance with combinational output, both DEPTH=8, checked each
// cycle against queue-based reference models plus directed scenario checks.
module tb_easy_fifo_pkt;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Packet instance (a_*)
  logic        a_wen, a_wlast, a_wdrop, a_ren;
  logic [15:0] a_wdata, a_rdata;
  logic        a_full, a_afull, a_ovf, a_rlast, a_empty, a_aempty;
  logic [3:0]  a_cnt;
  // Plain instance (b_*)
  logic        b_wen, b_wlast, b_wdrop, b_ren;
  logic [15:0] b_wdata, b_rdata;
  logic        b_full, b_afull, b_ovf, b_rlast, b_empty, b_aempty;
  logic [3:0]  b_cnt;

  easy_fifo_pkt #(.DWIDTH(16), .DEPTH(8), .PKT_MODE(1), .OUTPUT_REG(1)) u_pkt (
    .clk(clk), .rst_n(rst_n), .wr_data(a_wdata), .wr_en(a_wen), .wr_last(a_wlast),
    .wr_drop(a_wdrop), .wr_full(a_full), .wr_afull(a_afull), .pkt_overflow(a_ovf),
    .rd_en(a_ren), .rd_data(a_rdata), .rd_last(a_rlast), .rd_empty(a_empty),
    .rd_aempty(a_aempty), .fifo_cnt(a_cnt));

  easy_fifo_pkt #(.DWIDTH(16), .DEPTH(8), .PKT_MODE(0), .OUTPUT_REG(0)) u_plain (
    .clk(clk), .rst_n(rst_n), .wr_data(b_wdata), .wr_en(b_wen), .wr_last(b_wlast),
    .wr_drop(b_wdrop), .wr_full(b_full), .wr_afull(b_afull), .pkt_overflow(b_ovf),
    .rd_en(b_ren), .rd_data(b_rdata), .rd_last(b_rlast), .rd_empty(b_empty),
    .rd_aempty(b_aempty), .fifo_cnt(b_cnt));

  // Reference model: committed words in memory, open packet, discard flag,
  // output register, and a simple queue for the plain FIFO.
  logic [16:0] cq[$];
  logic [16:0] pq[$];
  logic [16:0] bq[$];
  bit          disc, ov, rv;
  logic [16:0] rw;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cq.delete(); pq.delete(); bq.delete();
    disc = 1'b0; ov = 1'b0; rv = 1'b0; rw = 17'h0;
  endtask

  task automatic check_all();
    int tot;
    tot = cq.size() + pq.size();
    chk("a_full",   a_full,   (!disc && tot == 8));
    chk("a_afull",  a_afull,  (tot >= 4));
    chk("a_ovf",    a_ovf,    ov);
    chk("a_empty",  a_empty,  !rv);
    chk("a_cnt",    a_cnt,    cq.size());
    chk("a_aempty", a_aempty, (cq.size() <= 4));
    if (rv) begin
      chk("a_rdata", a_rdata, rw[15:0]);
      chk("a_rlast", a_rlast, rw[16]);
    end
    chk("b_full",   b_full,   (bq.size() == 8));
    chk("b_afull",  b_afull,  (bq.size() >= 4));
    chk("b_ovf",    b_ovf,    1'b0);
    chk("b_empty",  b_empty,  (bq.size() == 0));
    chk("b_cnt",    b_cnt,    bq.size());
    chk("b_aempty", b_aempty, (bq.size() <= 4));
    if (bq.size() > 0) begin
      chk("b_rdata", b_rdata, bq[0][15:0]);
      chk("b_rlast", b_rlast, bq[0][16]);
    end
  endtask

  // Advance the model across one clock edge using the inputs of this cycle.
  task automatic model_edge();
    int  csz, tot, bsz;
    bit  full_pre, load;
    csz = cq.size();
    tot = csz + pq.size();
    full_pre = !disc && (tot == 8);
    load = (csz > 0) && (!rv || a_ren);
    if (load) begin
      rw = cq.pop_front();
      rv = 1'b1;
    end else if (a_ren) begin
      rv = 1'b0;
    end
    ov = 1'b0;
    if (disc) begin
      if (a_wdrop || (a_wen && a_wlast)) disc = 1'b0;
    end else if (a_wdrop) begin
      pq.delete();
    end else if (a_wen && !full_pre) begin
      pq.push_back({a_wlast, a_wdata});
      if (a_wlast) begin
        while (pq.size() > 0) cq.push_back(pq.pop_front());
      end else if ((tot + 1 == 8) && (csz == 0)) begin
        pq.delete();
        ov = 1'b1;
        disc = 1'b1;
      end
    end
    bsz = bq.size();
    if (b_ren && bsz > 0) void'(bq.pop_front());
    if (b_wen && bsz < 8) bq.push_back({b_wlast, b_wdata});
  endtask

  // One cycle: inputs are already applied just after the falling edge.
  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic aw(input bit en, input bit last, input bit drop, input logic [15:0] d, input bit ren);
    a_wen = en; a_wlast = last; a_wdrop = drop; a_wdata = d; a_ren = ren;
    b_wen = 1'b0; b_wlast = 1'b0; b_wdrop = 1'b0; b_wdata = 16'h0; b_ren = 1'b0;
    tick();
  endtask

  task automatic bw(input bit en, input logic [15:0] d, input bit ren);
    a_wen = 1'b0; a_wlast = 1'b0; a_wdrop = 1'b0; a_wdata = 16'h0; a_ren = 1'b0;
    b_wen = en; b_wlast = d[0]; b_wdrop = d[1]; b_wdata = d; b_ren = ren;
    tick();
  endtask

  initial begin
    a_wen = 1'b0; a_wlast = 1'b0; a_wdrop = 1'b0; a_wdata = 16'h0; a_ren = 1'b0;
    b_wen = 1'b0; b_wlast = 1'b0; b_wdrop = 1'b0; b_wdata = 16'h0; b_ren = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    // Reset values
    chk("rst_a_empty", a_empty, 1'b1);
    chk("rst_a_aempty", a_aempty, 1'b1);
    chk("rst_a_full", a_full, 1'b0);
    chk("rst_a_afull", a_afull, 1'b0);
    chk("rst_a_ovf", a_ovf, 1'b0);
    chk("rst_a_rdata", a_rdata, 16'h0);
    chk("rst_a_rlast", a_rlast, 1'b0);
    chk("rst_a_cnt", a_cnt, 4'd0);
    chk("rst_b_rdata", b_rdata, 16'h0);
    chk("rst_b_empty", b_empty, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: three-word packet, two-cycle visibility latency, ordered read-out
    aw(1'b1, 1'b0, 1'b0, 16'h1111, 1'b0);
    aw(1'b1, 1'b0, 1'b0, 16'h2222, 1'b0);
    aw(1'b1, 1'b1, 1'b0, 16'h3333, 1'b0);
    chk("t1_empty_n1", a_empty, 1'b1);
    chk("t1_cnt3", a_cnt, 4'd3);
    aw(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("t1_empty_n2", a_empty, 1'b0);
    chk("t1_head", a_rdata, 16'h1111);
    repeat (3) aw(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("t1_drained", a_empty, 1'b1);
    chk("t1_cnt0", a_cnt, 4'd0);

    // 2: partial packet dropped, following packet intact
    for (int i = 0; i < 5; i++) aw(1'b1, 1'b0, 1'b0, 16'hA000 + 16'(i), 1'b0);
    chk("t2_afull_pre", a_afull, 1'b1);
    aw(1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
    chk("t2_empty", a_empty, 1'b1);
    chk("t2_cnt", a_cnt, 4'd0);
    chk("t2_rewound", a_afull, 1'b0);
    aw(1'b1, 1'b0, 1'b0, 16'hB001, 1'b0);
    aw(1'b1, 1'b1, 1'b0, 16'hB002, 1'b0);
    aw(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("t2_head", a_rdata, 16'hB001);
    repeat (2) aw(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("t2_drained", a_empty, 1'b1);

    // 3: oversized packet auto-dropped, remainder swallowed until last
    for (int i = 0; i < 8; i++) aw(1'b1, 1'b0, 1'b0, 16'hC000 + 16'(i), 1'b0);
    chk("t3_ovf_pulse", a_ovf, 1'b1);
    chk("t3_full_disc", a_full, 1'b0);
    for (int i = 8; i < 12; i++) aw(1'b1, (i == 11), 1'b0, 16'hC000 + 16'(i), 1'b0);
    chk("t3_ovf_gone", a_ovf, 1'b0);
    chk("t3_empty", a_empty, 1'b1);
    chk("t3_cnt", a_cnt, 4'd0);
    chk("t3_afull", a_afull, 1'b0);
    aw(1'b1, 1'b1, 1'b0, 16'h5A5A, 1'b0);
    aw(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("t3_normal_head", a_rdata, 16'h5A5A);
    aw(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);

    // 4: plain FIFO fill, afull threshold, read+write at full
    for (int i = 0; i < 8; i++) begin
      bw(1'b1, 16'hD000 + 16'(i), 1'b0);
      if (i == 2) chk("t4_afull_3", b_afull, 1'b0);
      if (i == 3) chk("t4_afull_4", b_afull, 1'b1);
    end
    chk("t4_full", b_full, 1'b1);
    bw(1'b1, 16'hEEEE, 1'b1);
    chk("t4_full_drop", b_full, 1'b0);
    chk("t4_cnt7", b_cnt, 4'd7);
    chk("t4_head", b_rdata, 16'hD001);
    repeat (7) bw(1'b0, 16'h0, 1'b1);
    chk("t4_empty", b_empty, 1'b1);

    // 5: async reset mid-packet with committed words
    aw(1'b1, 1'b0, 1'b0, 16'hF001, 1'b0);
    aw(1'b1, 1'b0, 1'b0, 16'hF002, 1'b0);
    aw(1'b1, 1'b1, 1'b0, 16'hF003, 1'b0);
    bw(1'b1, 16'hF0F0, 1'b0);
    aw(1'b1, 1'b0, 1'b0, 16'hF004, 1'b0);
    aw(1'b1, 1'b0, 1'b0, 16'hF005, 1'b0);
    chk("t5_pre_valid", a_empty, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_empty_now", a_empty, 1'b1);
    chk("t5_cnt_now", a_cnt, 4'd0);
    chk("t5_rdata_now", a_rdata, 16'h0);
    chk("t5_b_empty_now", b_empty, 1'b1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) aw(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    aw(1'b1, 1'b0, 1'b0, 16'h0A01, 1'b0);
    aw(1'b1, 1'b1, 1'b0, 16'h0A02, 1'b0);
    aw(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("t5_new_head", a_rdata, 16'h0A01);
    repeat (2) aw(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);

    // Random traffic on both instances, read pressure varies per block
    for (int blk = 0; blk < 6; blk++) begin
      for (int c = 0; c < 100; c++) begin
        a_wen   = ($urandom_range(0, 9) < 6);
        a_wlast = ($urandom_range(0, 9) < 2);
        a_wdrop = ($urandom_range(0, 39) == 0);
        a_wdata = 16'($urandom);
        a_ren   = ($urandom_range(0, 9) < (blk * 2));
        b_wen   = ($urandom_range(0, 9) < 6);
        b_wlast = $urandom_range(0, 1);
        b_wdrop = $urandom_range(0, 1);
        b_wdata = 16'($urandom);
        b_ren   = ($urandom_range(0, 9) < (blk * 2));
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
